sha1_iter_core: RTL and testbench
=================================

// Module: sha1_iter_core
// PURPOSE
//  Iterative, clocked SHA-1 compression engine; successor to the single-block combinational top.
//  Folds the 80 rounds over 80/ROUNDS_PER_CYCLE cycles and chains any number of 512-bit blocks.
//  Sits between the padder/block feeder (valid/ready) and the digest consumer (valid/ready).
// PARAMETERS
//  ROUNDS_PER_CYCLE  1  rounds unrolled per clock; legal {1,2,4,5,8,10,16,20}; else $error at elaboration
// PORTS
//  clk_i         in   1    clock, all state on rising edge
//  rst_ni        in   1    synchronous, active-low reset
//  blk_valid_i   in   1    block_i/first_i/last_i valid
//  blk_ready_o   out  1    core accepts a block this cycle
//  block_i       in   512  message block; W[t] = block_i[32t+31:32t], t=0..15
//  first_i       in   1    block starts a new message: chain state reloaded before compression
//  last_i        in   1    block ends the message: digest presented after compression
//  dgst_valid_o  out  1    dgst_o valid
//  dgst_ready_i  in   1    consumer takes digest
//  dgst_o        out  160  {H4,H3,H2,H1,H0}; H0 in [31:0], H4 in [159:128]
// BEHAVIOUR
//  Reset (rst_ni=0 at an edge): state IDLE, H0..H4 = IV (67452301,efcdab89,98badcfe,10325476,c3d2e1f0),
//    blk_ready_o=1 after reset edge, dgst_valid_o=0, dgst_o=0, round counter=0. Reset mid-RUN/DONE aborts, no digest.
//  FSM: IDLE -> RUN on blk_valid_i & blk_ready_o; RUN -> IDLE (last_i=0) or DONE (last_i=1) after final round;
//    DONE -> IDLE on dgst_ready_i.
//  blk_ready_o = (state==IDLE). blk_valid_i outside IDLE ignored; block/flags latched only at handshake.
//  Handshake edge k: if first_i, working vars A..E and chain load IV, else current H0..H4.
//  RUN occupies edges k+1 .. k+N, N=80/ROUNDS_PER_CYCLE; each edge applies ROUNDS_PER_CYCLE rounds
//    with on-the-fly 16-word W ring (W[t]=rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16])).
//  Round functions: t<20 Ch, K=5a827999; t<40 Parity, 6ed9eba1; t<60 Maj, 8f1bbcdc; else Parity, ca62c1d6.
//  Edge k+N: H_i <= H_i + var_i mod 2^32; state -> IDLE or DONE. Next block accepted at edge k+N+1 earliest.
//  DONE: dgst_valid_o=1 from edge k+N; dgst_o stable until handshake; then H0..H4 reset to IV, dgst_valid_o=0.
//  dgst_ready_i in same cycle dgst_valid_o rises -> valid high exactly one cycle.
//  Block with first_i=0 after reset or after a digest handshake compresses against IV (implicit new message).
//  first_i=1 mid-message discards partial chain silently. first_i=last_i=1 = single-block message.
//  dgst_o outside DONE holds last accepted digest (0 after reset); only dgst_valid_o qualifies it.
//  No padding/length logic: the feeder supplies padded blocks.
// CONFIGURATION
//  SHA1_MIDSTATE_EN defined: extra ports midstate_i in 160 ({H4..H0} layout) and use_mid_i in 1, sampled at the
//    block handshake; first_i & use_mid_i loads midstate_i instead of IV (prefix precompute for nonce search).
//    use_mid_i with first_i=0 ignored.
//  Not defined: ports absent, first_i always loads IV.
// TESTING
//  "abc" one block: W0=61626380, W1..14=0, W15=00000018, first=last=1 -> after N+1 cycles
//    dgst_o={9cd0d89d,7850c26c,ba3e2571,4706816a,a9993e36}, dgst_valid_o=1.
//  Empty message: W0=80000000, rest 0 -> {afd80709,95601890,3255bfef,5e6b4b0d,da39a3ee}.
//  "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as 2 blocks (first, then last)
//    -> {e54670f1,f95129e5,baae4aa1,1c3bd26e,84983e44}; blk_ready_o low all RUN cycles.
//  Backpressure: dgst_ready_i=0 for 10 cycles -> dgst_o/valid held, blk_ready_o=0; release -> IDLE next edge.
//  rst_ni=0 at round 40 of "abc", then resubmit "empty" -> no spurious valid; empty digest correct.
//  SHA1_MIDSTATE_EN: run block 1 of 2-block vector, capture H; feed block 2 with first=1,use_mid=1,midstate=H
//    -> 84983e44 digest; sweep ROUNDS_PER_CYCLE over {1,5,20}, latency = 80/R+1 cycles.

Source files
------------

// File: rtl/sha1_iter_core_if.sv
`default_nettype none
// ============================================================================
// Module      : sha1_iter_core_if
// Description : Block-feed and digest handshake bundle for sha1_iter_core.
//               Optional midstate signals appear when SHA1_MIDSTATE_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface sha1_iter_core_if;
    logic         blk_valid_i;
    logic         blk_ready_o;
    logic [511:0] block_i;
    logic         first_i;
    logic         last_i;
    logic         dgst_valid_o;
    logic         dgst_ready_i;
    logic [159:0] dgst_o;
`ifdef SHA1_MIDSTATE_EN
    logic [159:0] midstate_i;
    logic         use_mid_i;
`endif

    // Core side
    modport slave (
        input  blk_valid_i,
        output blk_ready_o,
        input  block_i,
        input  first_i,
        input  last_i,
        output dgst_valid_o,
        input  dgst_ready_i,
        output dgst_o
`ifdef SHA1_MIDSTATE_EN
        ,
        input  midstate_i,
        input  use_mid_i
`endif
    );

    // Feeder / consumer side
    modport master (
        output blk_valid_i,
        input  blk_ready_o,
        output block_i,
        output first_i,
        output last_i,
        input  dgst_valid_o,
        output dgst_ready_i,
        input  dgst_o
`ifdef SHA1_MIDSTATE_EN
        ,
        output midstate_i,
        output use_mid_i
`endif
    );
endinterface
`default_nettype wire

// File: rtl/sha1_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : sha1_iter_core
// Description : Iterative SHA-1 compression engine. Runs the 80 rounds over
//               80/ROUNDS_PER_CYCLE clocks and chains 512-bit blocks into a
//               160-bit digest. Optional feature macro: SHA1_MIDSTATE_EN
//               (first block of a message may start from a supplied midstate).
// Revision    : 1.0 - initial release
// ============================================================================
module sha1_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    sha1_iter_core_if.slave    bus
);

    localparam int R = ROUNDS_PER_CYCLE;

    localparam bit PARAM_OK = (R == 1) || (R == 2) || (R == 4) || (R == 5) ||
                              (R == 8) || (R == 10) || (R == 16) || (R == 20);

    localparam logic [6:0] STEP     = 7'(R);
    localparam logic [6:0] LAST_CNT = 7'(80 - R);

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hefcdab89;
    localparam logic [31:0] IV2 = 32'h98badcfe;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hc3d2e1f0;
    localparam logic [159:0] IV = {IV4, IV3, IV2, IV1, IV0};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (!PARAM_OK) begin : g_bad_rounds
            $error("sha1_iter_core: ROUNDS_PER_CYCLE=%0d is not one of 1,2,4,5,8,10,16,20", R);
        end
    endgenerate

    logic [1:0]   state;
    logic [6:0]   cnt;
    logic         last_blk;
    logic [31:0]  h0, h1, h2, h3, h4;
    logic [31:0]  a, b, c, d, e;
    logic [511:0] w_ring;
    logic [159:0] dgst;

    logic [31:0]  ww [0:15+R];
    logic [511:0] w_next;
    logic [31:0]  na, nb, nc, nd, ne;
    logic [31:0]  tmp;
    logic [6:0]   rnd;
    logic [159:0] h_sum;
    logic [159:0] init_h;

    function automatic logic [31:0] f_fn(input logic [6:0] t, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] z);
        if (t < 7'd20)      f_fn = (x & y) | (~x & z);
        else if (t < 7'd40) f_fn = x ^ y ^ z;
        else if (t < 7'd60) f_fn = (x & y) | (x & z) | (y & z);
        else                f_fn = x ^ y ^ z;
    endfunction

    function automatic logic [31:0] k_fn(input logic [6:0] t);
        if (t < 7'd20)      k_fn = 32'h5a827999;
        else if (t < 7'd40) k_fn = 32'h6ed9eba1;
        else if (t < 7'd60) k_fn = 32'h8f1bbcdc;
        else                k_fn = 32'hca62c1d6;
    endfunction

    // Chain value loaded at a first_i handshake: IV, or the supplied midstate
`ifdef SHA1_MIDSTATE_EN
    assign init_h = bus.use_mid_i ? bus.midstate_i : IV;
`else
    assign init_h = IV;
`endif

    // R unrolled rounds: extend the schedule window by R words, then fold the rounds
    always_comb begin
        for (int i = 0; i < 16 + R; i++) ww[i] = '0;
        for (int i = 0; i < 16; i++) ww[i] = w_ring[32*i +: 32];
        for (int i = 0; i < R; i++) begin
            tmp        = ww[13+i] ^ ww[8+i] ^ ww[2+i] ^ ww[i];
            ww[16+i]   = {tmp[30:0], tmp[31]};
        end
        w_next = '0;
        for (int i = 0; i < 16; i++) w_next[32*i +: 32] = ww[R+i];

        na  = a;
        nb  = b;
        nc  = c;
        nd  = d;
        ne  = e;
        rnd = cnt;
        tmp = '0;
        for (int j = 0; j < R; j++) begin
            rnd = cnt + 7'(j);
            tmp = {na[26:0], na[31:27]} + f_fn(rnd, nb, nc, nd) + ne + k_fn(rnd) + ww[j];
            ne  = nd;
            nd  = nc;
            nc  = {nb[1:0], nb[31:2]};
            nb  = na;
            na  = tmp;
        end
        h_sum = {h4 + ne, h3 + nd, h2 + nc, h1 + nb, h0 + na};
    end

    // Control FSM, chain state, working variables and schedule window
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            last_blk <= 1'b0;
            h0       <= IV0;
            h1       <= IV1;
            h2       <= IV2;
            h3       <= IV3;
            h4       <= IV4;
            a        <= '0;
            b        <= '0;
            c        <= '0;
            d        <= '0;
            e        <= '0;
            w_ring   <= '0;
            dgst     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.blk_valid_i) begin
                        state    <= RUN;
                        cnt      <= '0;
                        last_blk <= bus.last_i;
                        w_ring   <= bus.block_i;
                        if (bus.first_i) begin
                            // A new message discards whatever chain was in progress
                            h0 <= init_h[31:0];
                            h1 <= init_h[63:32];
                            h2 <= init_h[95:64];
                            h3 <= init_h[127:96];
                            h4 <= init_h[159:128];
                            a  <= init_h[31:0];
                            b  <= init_h[63:32];
                            c  <= init_h[95:64];
                            d  <= init_h[127:96];
                            e  <= init_h[159:128];
                        end else begin
                            a <= h0;
                            b <= h1;
                            c <= h2;
                            d <= h3;
                            e <= h4;
                        end
                    end
                end
                RUN: begin
                    a      <= na;
                    b      <= nb;
                    c      <= nc;
                    d      <= nd;
                    e      <= ne;
                    w_ring <= w_next;
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        h0  <= h_sum[31:0];
                        h1  <= h_sum[63:32];
                        h2  <= h_sum[95:64];
                        h3  <= h_sum[127:96];
                        h4  <= h_sum[159:128];
                        if (last_blk) begin
                            dgst  <= h_sum;
                            state <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + STEP;
                    end
                end
                DONE: begin
                    if (bus.dgst_ready_i) begin
                        // Digest consumed: the next block starts a fresh message
                        h0    <= IV0;
                        h1    <= IV1;
                        h2    <= IV2;
                        h3    <= IV3;
                        h4    <= IV4;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.blk_ready_o  = (state == IDLE);
    assign bus.dgst_valid_o = (state == DONE);
    assign bus.dgst_o       = dgst;

endmodule
`default_nettype wire

// File: tb/tb_sha1_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha1_iter_core
// Description : Self-checking bench for sha1_iter_core: known vectors,
//               latency, backpressure, reset abort and randomized chaining
//               against a behavioural SHA-1 model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha1_iter_core;

    parameter int RPC = 5;
    localparam int N  = 80 / RPC;
    localparam logic [159:0] IV = {32'hc3d2e1f0, 32'h10325476, 32'h98badcfe,
                                   32'hefcdab89, 32'h67452301};
    localparam logic [159:0] ABC_D = {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571,
                                      32'h4706816a, 32'ha9993e36};
    localparam logic [159:0] EMPTY_D = {32'hafd80709, 32'h95601890, 32'h3255bfef,
                                        32'h5e6b4b0d, 32'hda39a3ee};
    localparam logic [159:0] TWO_D = {32'he54670f1, 32'hf95129e5, 32'hbaae4aa1,
                                      32'h1c3bd26e, 32'h84983e44};

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2;

    sha1_iter_core_if bus ();

    sha1_iter_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Textbook SHA-1 compression with a full 80-word schedule
    function automatic logic [159:0] ref_compress(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] wv [80];
        logic [31:0] va, vb, vc, vd, ve, f, k, t, x;
        for (int i = 0; i < 16; i++) wv[i] = blk[32*i +: 32];
        for (int i = 16; i < 80; i++) begin
            x     = wv[i-3] ^ wv[i-8] ^ wv[i-14] ^ wv[i-16];
            wv[i] = (x << 1) | (x >> 31);
        end
        va = hin[31:0]; vb = hin[63:32]; vc = hin[95:64]; vd = hin[127:96]; ve = hin[159:128];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (vb & vc) | (~vb & vd);            k = 32'h5a827999; end
            else if (i < 40) begin f = vb ^ vc ^ vd;                      k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (vb & vc) | (vb & vd) | (vc & vd); k = 32'h8f1bbcdc; end
            else             begin f = vb ^ vc ^ vd;                      k = 32'hca62c1d6; end
            t  = ((va << 5) | (va >> 27)) + f + ve + k + wv[i];
            ve = vd; vd = vc; vc = (vb << 30) | (vb >> 2); vb = va; va = t;
        end
        return {hin[159:128] + ve, hin[127:96] + vd, hin[95:64] + vc,
                hin[63:32] + vb, hin[31:0] + va};
    endfunction

    // Present one block at a negedge, wait for the handshake edge, then scramble the bus
    task automatic hs(input logic [511:0] blk, input bit f, input bit l, output bit ok);
        int g = 0;
        ok = 1'b0;
        while (bus.blk_ready_o !== 1'b1 && g < 500) begin @(negedge clk); g++; end
        if (bus.blk_ready_o === 1'b1) begin
            bus.block_i     = blk;
            bus.first_i     = f;
            bus.last_i      = l;
            bus.blk_valid_i = 1'b1;
            @(negedge clk);
            bus.blk_valid_i = 1'b0;
            bus.block_i     = {16{$urandom}};
            bus.first_i     = 1'($urandom);
            bus.last_i      = 1'($urandom);
            ok = 1'b1;
        end
    endtask

    // Edges elapsed (including the handshake edge) until dgst_valid_o is seen
    task automatic wait_dv(output int cyc);
        cyc = 1;
        while (bus.dgst_valid_o !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 1;
        while (bus.blk_ready_o !== 1'b1 && cyc < 500) begin @(negedge clk); cyc++; end
    endtask

    task automatic take_digest();
        bus.dgst_ready_i = 1'b1;
        @(negedge clk);
        bus.dgst_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.blk_ready_o !== 1'b1 || bus.dgst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b valid=%b, required ready=1 valid=0",
                     bus.blk_ready_o, bus.dgst_valid_o);
        end
        n_cmp++;
        if (bus.dgst_o !== 160'd0) begin
            n_fail++;
            $display("FAIL reset_dgst: got %h, required 0", bus.dgst_o);
        end
    endtask

    task automatic test_abc();
        bit ok; int cyc;
        hs(blk_abc, 1'b1, 1'b1, ok);
        wait_dv(cyc);
        n_cmp++;
        if (!ok || cyc != N + 1) begin
            n_fail++;
            $display("FAIL abc_latency: got %0d cycles (hs ok=%0b), required %0d", cyc, ok, N + 1);
        end
        n_cmp++;
        if (bus.dgst_o !== ABC_D) begin
            n_fail++;
            $display("FAIL abc_digest: got %h, required %h", bus.dgst_o, ABC_D);
        end
        take_digest();
    endtask

    task automatic test_empty();
        bit ok; int cyc;
        hs(blk_empty, 1'b1, 1'b1, ok);
        wait_dv(cyc);
        n_cmp++;
        if (!ok || bus.dgst_valid_o !== 1'b1 || bus.dgst_o !== EMPTY_D) begin
            n_fail++;
            $display("FAIL empty_digest: got %h valid=%b, required %h", bus.dgst_o, bus.dgst_valid_o, EMPTY_D);
        end
        take_digest();
    endtask

    task automatic test_two_block();
        bit ok1, ok2; int cyc;
        hs(blk_two1, 1'b1, 1'b0, ok1);
        wait_rdy(cyc);
        n_cmp++;
        if (!ok1 || cyc != N + 1 || bus.dgst_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL two_block_busy: ready after %0d cycles valid=%b, required %0d valid=0",
                     cyc, bus.dgst_valid_o, N + 1);
        end
        hs(blk_two2, 1'b0, 1'b1, ok2);
        wait_dv(cyc);
        n_cmp++;
        if (!ok2 || bus.dgst_o !== TWO_D) begin
            n_fail++;
            $display("FAIL two_block_digest: got %h, required %h", bus.dgst_o, TWO_D);
        end
        take_digest();
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; int bad;
        hs(blk_abc, 1'b1, 1'b1, ok);
        wait_dv(cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.dgst_valid_o !== 1'b1 || bus.blk_ready_o !== 1'b0 || bus.dgst_o !== ABC_D) bad++;
        end
        n_cmp++;
        if (!ok || bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d bad cycles, required 0", bad);
        end
        take_digest();
        n_cmp++;
        if (bus.dgst_valid_o !== 1'b0 || bus.blk_ready_o !== 1'b1 || bus.dgst_o !== ABC_D) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%b ready=%b dgst=%h, required 0/1/%h",
                     bus.dgst_valid_o, bus.blk_ready_o, bus.dgst_o, ABC_D);
        end
    endtask

    task automatic test_reset_abort();
        bit ok; int cyc;
        hs(blk_abc, 1'b1, 1'b1, ok);
        repeat (N / 2 - 1) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (bus.dgst_valid_o !== 1'b0 || bus.blk_ready_o !== 1'b1 || bus.dgst_o !== 160'd0) begin
            n_fail++;
            $display("FAIL abort_state: valid=%b ready=%b dgst=%h, required 0/1/0",
                     bus.dgst_valid_o, bus.blk_ready_o, bus.dgst_o);
        end
        // first_i=0 after reset still starts from IV
        hs(blk_empty, 1'b0, 1'b1, ok);
        wait_dv(cyc);
        n_cmp++;
        if (!ok || cyc != N + 1 || bus.dgst_o !== EMPTY_D) begin
            n_fail++;
            $display("FAIL abort_resubmit: got %h after %0d cycles, required %h after %0d",
                     bus.dgst_o, cyc, EMPTY_D, N + 1);
        end
        take_digest();
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; int high;
        bus.dgst_ready_i = 1'b1;
        hs(blk_empty, 1'b1, 1'b1, ok);
        wait_dv(cyc);
        high = 0;
        while (bus.dgst_valid_o === 1'b1 && high < 5) begin high++; @(negedge clk); end
        n_cmp++;
        if (!ok || high != 1 || bus.blk_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_pulse: valid high %0d cycles ready=%b, required 1 cycle ready=1",
                     high, bus.blk_ready_o);
        end
        hs(blk_abc, 1'b1, 1'b1, ok);
        wait_dv(cyc);
        n_cmp++;
        if (!ok || cyc != N + 1 || bus.dgst_o !== ABC_D) begin
            n_fail++;
            $display("FAIL b2b_second: got %h after %0d cycles, required %h after %0d",
                     bus.dgst_o, cyc, ABC_D, N + 1);
        end
        @(negedge clk);
        bus.dgst_ready_i = 1'b0;
    endtask

    task automatic test_random();
        logic [159:0] chain;
        logic [511:0] blk;
        bit f, l, ok; int cyc;
        chain = IV;
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
            f = ($urandom_range(0, 2) == 0);
            l = ($urandom_range(0, 2) == 0) || (n == 15);
            if (f) chain = IV;
            chain = ref_compress(chain, blk);
            hs(blk, f, l, ok);
            if (l) begin
                wait_dv(cyc);
                n_cmp++;
                if (!ok || cyc != N + 1 || bus.dgst_o !== chain) begin
                    n_fail++;
                    $display("FAIL random_digest[%0d]: got %h after %0d cycles, required %h",
                             n, bus.dgst_o, cyc, chain);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                take_digest();
                chain = IV;
            end else begin
                wait_rdy(cyc);
                n_cmp++;
                if (!ok || cyc != N + 1 || bus.dgst_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random_mid[%0d]: ready after %0d valid=%b, required %0d valid=0",
                             n, cyc, bus.dgst_valid_o, N + 1);
                end
            end
        end
    endtask

`ifdef SHA1_MIDSTATE_EN
    task automatic test_midstate();
        bit ok; int cyc;
        bus.midstate_i = ref_compress(IV, blk_two1);
        bus.use_mid_i  = 1'b1;
        hs(blk_two2, 1'b1, 1'b1, ok);
        bus.use_mid_i  = 1'b0;
        bus.midstate_i = '0;
        wait_dv(cyc);
        n_cmp++;
        if (!ok || cyc != N + 1 || bus.dgst_o !== TWO_D) begin
            n_fail++;
            $display("FAIL midstate_digest: got %h after %0d cycles, required %h", bus.dgst_o, cyc, TWO_D);
        end
        take_digest();
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.blk_valid_i  = 1'b0;
        bus.block_i      = '0;
        bus.first_i      = 1'b0;
        bus.last_i       = 1'b0;
        bus.dgst_ready_i = 1'b0;
`ifdef SHA1_MIDSTATE_EN
        bus.midstate_i   = '0;
        bus.use_mid_i    = 1'b0;
`endif
        blk_abc   = '0; blk_abc[31:0] = 32'h61626380; blk_abc[511:480] = 32'h00000018;
        blk_empty = '0; blk_empty[31:0] = 32'h80000000;
        blk_two1  = '0;
        for (int i = 0; i < 14; i++)
            blk_two1[32*i +: 32] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
        blk_two1[14*32 +: 32] = 32'h80000000;
        blk_two2  = '0; blk_two2[511:480] = 32'h000001c0;

        @(negedge clk);
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef SHA1_MIDSTATE_EN
        test_midstate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
